// File: rtl/wb_accum_array.sv
// ---------------------------------------------------------------------------
// wb_accum_array
//   Bank of CHANNELS independent WIDTH-bit add/sub accumulators sitting on a
//   Wishbone slave port. Each channel owns an operand, an accumulator, a
//   control word and a sticky overflow flag. Writing a channel's OPERAND
//   register launches the operation selected in its CTRL register. The bus
//   FSM serialises every access.
//
//   Register map (per channel, ch = adr[7:4], reg = adr[3:2]):
//     0 OPERAND  W launches op, R returns last operand
//     1 ACC      R/W, a write loads directly without touching ovf
//     2 CTRL     [1:0] op (add/sub/load/clear), [2] sat, [3] irq_en
//     3 STATUS   [0] ovf, write-1-to-clear through sel[0]
//
// Ports
//   wb_clk_i, wb_rst_ni           clock, async active-low reset
//   wbs_stb_i/cyc_i/we_i/sel_i    Wishbone request qualifiers
//   wbs_adr_i, wbs_dat_i          Wishbone address / write data
//   wbs_ack_o, wbs_dat_o          single-cycle ack / read data (held)
//   acc_o                         all accumulators, channel 0 in the LSBs
//   ovf_o                         sticky overflow flag per channel
//   busy_o                        high while an operation executes
//   irq_o                         level interrupt, |(ovf & irq_en)
// ---------------------------------------------------------------------------
module wb_accum_array #(
    parameter int          WIDTH     = 32,
    parameter int          CHANNELS  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic [CHANNELS*WIDTH-1:0] acc_o,
    output logic [CHANNELS-1:0]       ovf_o,
    output logic                      busy_o,
    output logic                      irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [4:0] NUM_CH = 5'(CHANNELS);

    // Byte-lane merge of new write data into an old register value.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel_v);
        logic [31:0] res_v;
        res_v = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel_v[b]) begin
                res_v[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res_v[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res_v;
    endfunction

    // One accumulator step. Returns {ovf_set, new_acc}.
    function automatic logic [WIDTH:0] acc_step(input logic [1:0]       op_v,
                                                 input logic             sat_v,
                                                 input logic [WIDTH-1:0] acc_v,
                                                 input logic [WIDTH-1:0] opnd_v);
        logic [WIDTH:0] ext_v;
        logic [WIDTH:0] res_v;
        ext_v = {(WIDTH+1){1'b0}};
        res_v = {1'b0, acc_v};
        case (op_v)
            2'b00: begin
                // Bit WIDTH of the widened sum is the carry-out.
                ext_v = {1'b0, acc_v} + {1'b0, opnd_v};
                if (ext_v[WIDTH]) begin
                    res_v = {1'b1, (sat_v ? {WIDTH{1'b1}} : ext_v[WIDTH-1:0])};
                end else begin
                    res_v = {1'b0, ext_v[WIDTH-1:0]};
                end
            end
            2'b01: begin
                // Bit WIDTH of the widened difference is the borrow.
                ext_v = {1'b0, acc_v} - {1'b0, opnd_v};
                if (ext_v[WIDTH]) begin
                    res_v = {1'b1, (sat_v ? {WIDTH{1'b0}} : ext_v[WIDTH-1:0])};
                end else begin
                    res_v = {1'b0, ext_v[WIDTH-1:0]};
                end
            end
            2'b10:   res_v = {1'b0, opnd_v};
            2'b11:   res_v = {(WIDTH+1){1'b0}};
            default: res_v = {1'b0, acc_v};
        endcase
        return res_v;
    endfunction

    state_t              state_r;
    logic                ack_r;
    logic [31:0]         dat_r;
    logic                busy_r;
    logic                irq_r;
    logic [3:0]          pend_ch_r;

    logic [WIDTH-1:0]    acc_r    [CHANNELS];
    logic [WIDTH-1:0]    opnd_r   [CHANNELS];
    logic [3:0]          ctrl_r   [CHANNELS];
    logic [CHANNELS-1:0] ovf_r;

    logic [WIDTH-1:0]    acc_nx_s  [CHANNELS];
    logic [WIDTH-1:0]    opnd_nx_s [CHANNELS];
    logic [3:0]          ctrl_nx_s [CHANNELS];
    logic [CHANNELS-1:0] ovf_nx_s;
    logic [CHANNELS-1:0] irq_en_nx_s;
    logic [WIDTH:0]      op_res_s;

    logic                req_s;
    logic                hit_s;
    logic [3:0]          ch_s;
    logic [1:0]          reg_s;
    logic                launch_s;
    logic                wr_s;
    logic [31:0]         rd_data_s;
    logic                unused_adr_s;

    assign ch_s     = wbs_adr_i[7:4];
    assign reg_s    = wbs_adr_i[3:2];
    assign hit_s    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]) && ({1'b0, ch_s} < NUM_CH);
    assign req_s    = (state_r == ST_IDLE) && wbs_cyc_i && wbs_stb_i && !ack_r;
    assign launch_s = req_s && wbs_we_i && hit_s && (reg_s == 2'd0);
    assign wr_s     = req_s && wbs_we_i && hit_s && (reg_s != 2'd0);
    assign unused_adr_s = ^wbs_adr_i[1:0];

    // Read mux: out-of-range addresses fall through to zero.
    always_comb begin
        rd_data_s = 32'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (hit_s && (ch_s == i[3:0])) begin
                case (reg_s)
                    2'd0:    rd_data_s[WIDTH-1:0] = opnd_r[i];
                    2'd1:    rd_data_s[WIDTH-1:0] = acc_r[i];
                    2'd2:    rd_data_s[3:0]       = ctrl_r[i];
                    2'd3:    rd_data_s[0]         = ovf_r[i];
                    default: rd_data_s            = 32'd0;
                endcase
            end else begin
            end
        end
    end

    // Next-state of the register bank: bus writes in IDLE, op commit in EXEC.
    always_comb begin
        acc_nx_s    = acc_r;
        opnd_nx_s   = opnd_r;
        ctrl_nx_s   = ctrl_r;
        ovf_nx_s    = ovf_r;
        irq_en_nx_s = {CHANNELS{1'b0}};
        op_res_s    = {(WIDTH+1){1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            if (launch_s && (ch_s == i[3:0])) begin
                opnd_nx_s[i] = WIDTH'(byte_merge(32'(opnd_r[i]), wbs_dat_i, wbs_sel_i));
            end else if (wr_s && (ch_s == i[3:0])) begin
                case (reg_s)
                    2'd1: acc_nx_s[i] = WIDTH'(byte_merge(32'(acc_r[i]), wbs_dat_i, wbs_sel_i));
                    2'd2: begin
                        if (wbs_sel_i[0]) begin
                            ctrl_nx_s[i] = wbs_dat_i[3:0];
                        end else begin
                            ctrl_nx_s[i] = ctrl_r[i];
                        end
                    end
                    2'd3: begin
                        if (wbs_sel_i[0] && wbs_dat_i[0]) begin
                            ovf_nx_s[i] = 1'b0;
                        end else begin
                            ovf_nx_s[i] = ovf_r[i];
                        end
                    end
                    default: acc_nx_s[i] = acc_r[i];
                endcase
            end else if ((state_r == ST_EXEC) && (pend_ch_r == i[3:0])) begin
                op_res_s     = acc_step(ctrl_r[i][1:0], ctrl_r[i][2], acc_r[i], opnd_r[i]);
                acc_nx_s[i]  = op_res_s[WIDTH-1:0];
                ovf_nx_s[i]  = ovf_r[i] | op_res_s[WIDTH];
            end else begin
                acc_nx_s[i]  = acc_r[i];
            end
            irq_en_nx_s[i] = ctrl_nx_s[i][3];
        end
    end

    // Register bank; irq is registered from the same next-state as ovf so the
    // two always change on the same edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_r[i]  <= {WIDTH{1'b0}};
                opnd_r[i] <= {WIDTH{1'b0}};
                ctrl_r[i] <= 4'd0;
            end
            ovf_r <= {CHANNELS{1'b0}};
            irq_r <= 1'b0;
        end else begin
            acc_r  <= acc_nx_s;
            opnd_r <= opnd_nx_s;
            ctrl_r <= ctrl_nx_s;
            ovf_r  <= ovf_nx_s;
            irq_r  <= |(ovf_nx_s & irq_en_nx_s);
        end
    end

    // Bus FSM with registered ack, read data and busy.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r   <= ST_IDLE;
            ack_r     <= 1'b0;
            dat_r     <= 32'd0;
            busy_r    <= 1'b0;
            pend_ch_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r <= 1'b0;
                    if (launch_s) begin
                        state_r   <= ST_EXEC;
                        busy_r    <= 1'b1;
                        pend_ch_r <= ch_s;
                    end else if (req_s) begin
                        state_r <= ST_ACK;
                        ack_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        if (!wbs_we_i) begin
                            dat_r <= rd_data_s;
                        end else begin
                            dat_r <= dat_r;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    busy_r <= 1'b0;
                    // The op commits regardless; only the ack depends on the
                    // master still holding the cycle.
                    if (wbs_cyc_i && wbs_stb_i) begin
                        state_r <= ST_ACK;
                        ack_r   <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        ack_r   <= 1'b0;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_acc
        assign acc_o[g*WIDTH +: WIDTH] = acc_r[g];
    end

    assign ovf_o     = ovf_r;
    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = dat_r;
    assign busy_o    = busy_r;
    assign irq_o     = irq_r;

endmodule
